// File: rtl/gray_sched_pkg.sv
// Shared types, constants and the round-robin index helper for gray_conv_sched.
package gray_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // First set bit of valid at or after ptr, wrapping at nreq (nreq <= 8).
  // Scans from the farthest offset down so the nearest valid index wins.
  function automatic logic [2:0] rr_next(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int unsigned nreq);
    logic [2:0] r;
    int unsigned i;
    r = '0;
    for (int unsigned k = nreq; k > 0; k--) begin
      i = (32'(ptr) + k - 1) % nreq;
      if (valid[3'(i)]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/b2g_core.sv
// Combinational binary-to-Gray converter.
module b2g_core #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] b,
  output logic [N-1:0] g
);

  assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one b2g_core among NREQ requesters.
// Optional GRAY_SCHED_STATS_EN adds a saturating conv_count output.
module gray_conv_sched
  import gray_sched_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [IDW-1:0]    out_id
`ifdef GRAY_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]  conv_count
`endif
);

  state_t         state, state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_idx;
  logic           grant;
  logic [N-1:0]   op_reg;
  logic [IDW-1:0] id_reg;
  logic [N-1:0]   gray;

  assign pick_idx = IDW'(rr_next(8'(req_valid), 3'(ptr), NREQ));

  b2g_core #(.N(N)) u_b2g (
    .b (op_reg),
    .g (gray)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // rst gates req_ready so no grant is visible while reset is held.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready[pick_idx] = 1'b1;
          grant               = 1'b1;
          state_next          = CONVERT;
        end
      end
      CONVERT: state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      op_reg    <= '0;
      id_reg    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      if (grant) begin
        op_reg <= req_data[int'(pick_idx)*N +: N];
        id_reg <= pick_idx;
        ptr    <= pick_idx + IDW'(1);
      end
      if (state == CONVERT) begin
        out_data  <= gray;
        out_id    <= id_reg;
        out_valid <= 1'b1;
      end
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

`ifdef GRAY_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conv_count <= '0;
    else if (state == HOLD && out_ready && conv_count != CNT_MAX)
      conv_count <= conv_count + CNT_W'(1);
  end
`endif

endmodule

// File: doc/gray_conv_sched.md
# gray_conv_sched

Round-robin scheduler that time-shares one N-bit binary-to-Gray converter among NREQ requesters. Each requester presents a binary word with a valid/ready handshake. The block grants one requester at a time, runs the shared converter, and returns the Gray result tagged with the requester ID on a single valid/ready output port. It sits between client code-conversion users and the single converter instance.

## Interface
- `N`, 8, data width of binary and Gray words (N ≥ 2)
- `NREQ`, 4, number of requesters (power of 2, 2..8); `IDW = $clog2(NREQ)`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_data`  in  NREQ*N  requester i's binary word occupies bits [i*N +: N]
- `req_ready`  out  NREQ  one-hot accept strobe
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  N  Gray code of the granted word
- `out_id`  out  IDW  index of the requester that produced `out_data`
- `conv_count`  out  16  completed transactions; present only with `GRAY_SCHED_STATS_EN`

## Operation
- FSM states: IDLE, CONVERT, HOLD.
- **IDLE**
  - If any `req_valid` is high, pick the first valid index at or after `ptr` (round-robin, wrapping NREQ-1→0).
  - Assert that index's `req_ready` combinationally in the same cycle.
  - Capture `req_data` slice into `op_reg` and the index into `id_reg`.
  - Set `ptr` ← index+1 (mod NREQ). Go to CONVERT.
  - If no request is valid, stay in IDLE and hold `ptr`.
- **CONVERT**
  - `out_data` ← `op_reg ^ (op_reg >> 1)` (MSB passes through unchanged).
  - `out_id` ← `id_reg`; `out_valid` ← 1. Go to HOLD.
- **HOLD**
  - Hold `out_valid`, `out_data` and `out_id` stable until `out_ready` is high.
  - On the handshake cycle, clear `out_valid` at the next edge, increment `conv_count`, and go to IDLE.
- `req_ready` is high only in IDLE and only for the granted index; all other bits are 0.
- Requests arriving in CONVERT or HOLD wait; requesters must hold `req_valid` and `req_data` until accepted.
- `req_valid` dropping before grant is legal; the request is simply not granted.
- `ptr` advances only on a grant.
- **Reset** (at any time, including mid-transaction):
  - State ← IDLE, `ptr` ← 0.
  - `out_valid`, `out_data`, `out_id`, `op_reg`, `id_reg`, `conv_count` ← 0.
  - An in-flight result is discarded; no `req_ready` is asserted while `rst` is high.

## Timing
- Request accepted at edge T (`req_valid` & `req_ready`).
- `out_valid` is high from after edge T+1 onward, i.e. visible in the cycle following the CONVERT cycle.
- With `out_ready` held high, `out_valid` lasts exactly 1 cycle.
- The next grant can occur in the cycle after the output handshake.
- Maximum throughput: one result per 3 cycles.
- All outputs are registered except `req_ready`, which is combinational from state, `ptr` and `req_valid`.

## Configuration
- **`GRAY_SCHED_STATS_EN` defined:**
  - Adds the `conv_count` port: a 16-bit counter of completed output handshakes.
  - Saturates at 16'hFFFF (no wrap).
  - Reset to 0.
- **Not defined:** the port and counter are absent; all other behaviour is identical.

## Structure
- **Package `gray_sched_pkg`:**
  - State enum (IDLE=2'd0, CONVERT=2'd1, HOLD=2'd2).
  - `CNT_W=16`, `CNT_MAX` constants.
  - Round-robin next-index function.
- **Sub-module `b2g_core`:**
  - Purely combinational, parameter N.
  - Computes `g = b ^ (b >> 1)`.
  - Instantiated once and driven by `op_reg`.

## Test plan
- **Single request:** reset, then requester 2 sends `req_data`=8'h24 with `out_ready`=1.
  - `req_ready`=4'b0100 for 1 cycle.
  - `out_data`=8'h36 and `out_id`=2, with `out_valid` high for 1 cycle.
- **Round-robin fairness:** all four requesters valid continuously with words 8'h81, 8'h63, 8'h0D, 8'h09.
  - Grant order 0,1,2,3,0.
  - Outputs 8'hC1, 8'h52, 8'h0B, 8'h0D.
- **Backpressure:** requester 1 sends 8'h8D with `out_ready`=0 for 5 cycles.
  - `out_data`=8'hCB stays stable and `out_valid` stays high.
  - No `req_ready` is asserted meanwhile, even with requester 3 valid.
  - After release, requester 3 is granted next.
- **Pointer wrap and skip:** only requesters 3 and 1 valid, starting with `ptr`=2.
  - Grant 3, then 1 (wrap past 0).
- **Reset mid-operation:** assert `rst` during HOLD.
  - `out_valid`=0 immediately (async).
  - After release, requesters 0 and 3 both valid → 0 granted first (`ptr`=0).
- **Stats** (`GRAY_SCHED_STATS_EN`): 10 completed transactions give `conv_count`=10.
  - Force the counter near 16'hFFFF: it holds at 16'hFFFF after further completions.
